// File: rtl/spi_txn_ctrl.sv
// SPI master transaction sequencer: TX/RX byte FIFOs, chip-select framing and spi_master handshake.
// Optional `define SPI_TXN_OVF_EN adds the sticky rx_ovf flag and its ovf_clr input.

module spi_txn_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wptr_r;
    logic [AW:0] rptr_r;
    logic        push_ok_s;
    logic        pop_ok_s;

    // Pointers carry one wrap bit so full and empty are told apart without a counter
    assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign empty     = (wptr_r == rptr_r);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rptr_r[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_r <= '0;
            rptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wptr_r[AW-1:0]] <= wdata;
                wptr_r                <= wptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
        end
    end
endmodule

module spi_txn_ctrl #(
    parameter int FIFO_DEPTH   = 8,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpol_cfg,
    input  logic       cpha_cfg,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx_full,
    input  logic       go,
    output logic       busy,
    output logic       xfer_done,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rx_empty,
    output logic       cpol,
    output logic       cpha,
    output logic       m_start,
    output logic [7:0] m_tx_data,
    input  logic       m_tx_ready,
    input  logic       m_done,
    input  logic [7:0] m_rx_data,
    output logic       cs
`ifdef SPI_TXN_OVF_EN
    ,
    output logic       rx_ovf,
    input  logic       ovf_clr
`endif
);
    localparam int CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYC - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          cs_r;
    logic          cs_nxt_s;
    logic          busy_r;
    logic          xfer_done_r;
    logic          m_start_r;
    logic [7:0]    m_tx_data_r;
    logic          cpol_r;
    logic          cpha_r;

    logic          latch_s;
    logic          start_s;
    logic          done_s;
    logic          tx_pop_s;
    logic          rx_cap_s;
    logic          rx_push_s;
    logic          tx_empty_s;
    logic          rx_full_s;
    logic [7:0]    tx_head_s;

    spi_txn_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .wdata (wr_data),
        .pop   (tx_pop_s),
        .rdata (tx_head_s),
        .full  (tx_full),
        .empty (tx_empty_s)
    );

    spi_txn_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push_s),
        .wdata (m_rx_data),
        .pop   (rd_en),
        .rdata (rd_data),
        .full  (rx_full_s),
        .empty (rx_empty)
    );

    // A byte arriving on a full RX FIFO is dropped without stalling the transfer
    assign rx_push_s = rx_cap_s && !rx_full_s;

    // Transaction sequencing
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cs_nxt_s    = cs_r;
        latch_s     = 1'b0;
        start_s     = 1'b0;
        done_s      = 1'b0;
        tx_pop_s    = 1'b0;
        rx_cap_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (go && !tx_empty_s) begin
                    latch_s     = 1'b1;
                    cs_nxt_s    = 1'b0;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            ST_LOAD: begin
                if (m_tx_ready) begin
                    if (!tx_empty_s) begin
                        start_s     = 1'b1;
                        tx_pop_s    = 1'b1;
                        state_nxt_s = ST_WAIT;
                    end else begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_WAIT: begin
                if (m_done) begin
                    rx_cap_s = 1'b1;
                    // A push landing this cycle still keeps the burst going
                    if (!tx_empty_s || wr_en) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    cs_nxt_s    = 1'b1;
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                cs_nxt_s    = 1'b1;
                cnt_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered state and all handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            cs_r        <= 1'b1;
            busy_r      <= 1'b0;
            xfer_done_r <= 1'b0;
            m_start_r   <= 1'b0;
            m_tx_data_r <= 8'h00;
            cpol_r      <= 1'b0;
            cpha_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            cs_r        <= cs_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            xfer_done_r <= done_s;
            m_start_r   <= start_s;
            if (start_s) begin
                m_tx_data_r <= tx_head_s;
            end
            if (latch_s) begin
                cpol_r <= cpol_cfg;
                cpha_r <= cpha_cfg;
            end
        end
    end

    assign cs        = cs_r;
    assign busy      = busy_r;
    assign xfer_done = xfer_done_r;
    assign m_start   = m_start_r;
    assign m_tx_data = m_tx_data_r;
    assign cpol      = cpol_r;
    assign cpha      = cpha_r;

`ifdef SPI_TXN_OVF_EN
    logic rx_ovf_r;
    logic rx_drop_s;

    assign rx_drop_s = rx_cap_s && rx_full_s;

    // Sticky overflow flag; a drop wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ovf_r <= 1'b0;
        end else if (rx_drop_s) begin
            rx_ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            rx_ovf_r <= 1'b0;
        end
    end

    assign rx_ovf = rx_ovf_r;
`endif
endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Bench for spi_txn_ctrl: queue-based reference model, emulated spi_master, directed and random phases.
module tb_spi_txn_ctrl;
    localparam int D  = 8;
    localparam int SU = 2;
    localparam int HD = 2;

    logic       clk = 1'b0;
    logic       reset, cpol_cfg, cpha_cfg, wr_en, go, rd_en, m_tx_ready, m_done;
    logic [7:0] wr_data, m_rx_data;
    logic       tx_full, busy, xfer_done, rx_empty, cpol, cpha, m_start, cs;
    logic [7:0] rd_data, m_tx_data;
`ifdef SPI_TXN_OVF_EN
    logic       rx_ovf, ovf_clr;
`endif

    always #5 clk = ~clk;

    spi_txn_ctrl #(.FIFO_DEPTH(D), .CS_SETUP_CYC(SU), .CS_HOLD_CYC(HD)) dut (
        .clk(clk), .reset(reset), .cpol_cfg(cpol_cfg), .cpha_cfg(cpha_cfg),
        .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .go(go), .busy(busy),
        .xfer_done(xfer_done), .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
        .cpol(cpol), .cpha(cpha), .m_start(m_start), .m_tx_data(m_tx_data),
        .m_tx_ready(m_tx_ready), .m_done(m_done), .m_rx_data(m_rx_data), .cs(cs)
`ifdef SPI_TXN_OVF_EN
        , .rx_ovf(rx_ovf), .ovf_clr(ovf_clr)
`endif
    );

    // reference model: byte queues plus countdowns for the cs framing
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         e_cs, e_busy, e_xd, e_ms, e_cpol, e_cpha, e_ovf;
    logic [7:0] e_md;
    int         setup_left, hold_left;
    bit         loading, waiting;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_go, t_start, t_xd, t_done;
    int ms_cnt = 0;
    int xd_cnt = 0;
    logic [7:0] sent[$];

    int         sl_cnt = 0;
    bit         sl_fixed = 1'b1;
    bit         rnd_stall = 1'b0;
    bit         cfg_toggle = 1'b0;
    logic [7:0] sl_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        e_cs = 1'b1; e_busy = 1'b0; e_xd = 1'b0; e_ms = 1'b0;
        e_cpol = 1'b0; e_cpha = 1'b0; e_ovf = 1'b0; e_md = 8'h00;
        setup_left = 0; hold_left = 0; loading = 1'b0; waiting = 1'b0;
    endtask

    task automatic model_step();
        int txn, rxn;
        bit tx_push, rx_pop, drop, clr;
        txn = tx_q.size();
        rxn = rx_q.size();
        tx_push = wr_en && (txn < D);
        rx_pop  = rd_en && (rxn > 0);
        drop = 1'b0;
`ifdef SPI_TXN_OVF_EN
        clr = ovf_clr;
`else
        clr = 1'b0;
`endif
        e_xd = 1'b0;
        e_ms = 1'b0;
        if (rx_pop) void'(rx_q.pop_front());
        if (!e_busy) begin
            if (go && txn > 0) begin
                e_cpol = cpol_cfg; e_cpha = cpha_cfg;
                e_cs = 1'b0; e_busy = 1'b1; setup_left = SU;
            end
        end else if (setup_left > 0) begin
            setup_left--;
            if (setup_left == 0) loading = 1'b1;
        end else if (loading) begin
            if (m_tx_ready && tx_q.size() > 0) begin
                e_ms = 1'b1; e_md = tx_q.pop_front();
                loading = 1'b0; waiting = 1'b1;
            end
        end else if (waiting) begin
            if (m_done) begin
                if (rxn < D) rx_q.push_back(m_rx_data);
                else drop = 1'b1;
                waiting = 1'b0;
                if (tx_q.size() > 0 || tx_push) loading = 1'b1;
                else hold_left = HD;
            end
        end else if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) begin
                e_cs = 1'b1; e_busy = 1'b0; e_xd = 1'b1;
            end
        end
        if (tx_push) tx_q.push_back(wr_data);
        if (drop) e_ovf = 1'b1;
        else if (clr) e_ovf = 1'b0;
    endtask

    task automatic compare();
        chk("cs", cs, e_cs);
        chk("busy", busy, e_busy);
        chk("xfer_done", xfer_done, e_xd);
        chk("m_start", m_start, e_ms);
        chk("m_tx_data", m_tx_data, e_md);
        chk("cpol", cpol, e_cpol);
        chk("cpha", cpha, e_cpha);
        chk("tx_full", tx_full, (tx_q.size() == D));
        chk("rx_empty", rx_empty, (rx_q.size() == 0));
        if (rx_q.size() > 0) chk("rd_data", rd_data, rx_q[0]);
`ifdef SPI_TXN_OVF_EN
        chk("rx_ovf", rx_ovf, e_ovf);
`endif
        if (m_start === 1'b1) begin ms_cnt++; t_start = cyc; sent.push_back(m_tx_data); end
        if (xfer_done === 1'b1) begin xd_cnt++; t_xd = cyc; end
    endtask

    // emulated spi_master: answers each m_start with m_done after a few cycles
    task automatic slave_update();
        m_done = 1'b0;
        if (sl_cnt > 0) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
                m_done = 1'b1;
                t_done = cyc + 1;
                if (sl_fixed && sl_q.size() > 0) m_rx_data = sl_q.pop_front();
                else m_rx_data = 8'($urandom);
            end
        end
        if (m_start === 1'b1) sl_cnt = sl_fixed ? 2 : $urandom_range(1, 5);
        m_tx_ready = (sl_cnt == 0) && !(rnd_stall && ($urandom_range(0, 3) == 0));
        if (cfg_toggle) begin cpol_cfg = 1'($urandom); cpha_cfg = 1'($urandom); end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        compare();
        slave_update();
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        t_go = cyc;
        go = 1'b0;
    endtask

    task automatic pop_rx();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_xd(input int lim);
        int x0 = xd_cnt;
        for (int i = 0; i < lim && xd_cnt == x0; i++) tick();
        if (xd_cnt == x0) chk("xfer_done_timeout", xd_cnt - x0, 1);
    endtask

    task automatic drain_rx();
        for (int i = 0; i < 2 * D && rx_empty === 1'b0; i++) pop_rx();
    endtask

    function automatic logic [7:0] sent_at(input int i);
        if (i < sent.size()) return sent[i];
        return 8'hxx;
    endfunction

    initial begin
        int ms0, xd0, n;
        logic [7:0] b4 [4];
        logic [7:0] r4 [4];
        b4 = '{8'hF0, 8'h0F, 8'hAA, 8'h55};
        r4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset = 1'b1; cpol_cfg = 1'b0; cpha_cfg = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        go = 1'b0; rd_en = 1'b0; m_tx_ready = 1'b1; m_done = 1'b0; m_rx_data = 8'h00;
`ifdef SPI_TXN_OVF_EN
        ovf_clr = 1'b0;
`endif
        model_reset();
        tick(); tick();
        chk("rst_cs", cs, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_m_tx_data", m_tx_data, 8'h00);
        chk("rst_tx_full", tx_full, 1'b0);
        reset = 1'b0;
        tick();

        // single byte, mode 0, slave answers AA
        sl_q.push_back(8'hAA);
        ms0 = ms_cnt; sent.delete();
        push(8'hF0);
        pulse_go();
        chk("A_cs_low", cs, 1'b0);
        wait_xd(60);
        chk("A_starts", ms_cnt - ms0, 1);
        chk("A_txbyte", sent_at(0), 8'hF0);
        chk("A_latency", t_start - t_go, SU + 1);
        chk("A_hold", t_xd - t_done, HD);
        chk("A_rd_data", rd_data, 8'hAA);
        chk("A_rx_empty", rx_empty, 1'b0);
        chk("A_cs_high", cs, 1'b1);
        pop_rx();
        chk("A_rx_drained", rx_empty, 1'b1);

        // four-byte burst with a go while busy
        for (int i = 0; i < 4; i++) begin push(b4[i]); sl_q.push_back(r4[i]); end
        ms0 = ms_cnt; xd0 = xd_cnt; sent.delete();
        pulse_go();
        tick(); tick(); tick();
        pulse_go();
        wait_xd(100);
        tick(); tick(); tick();
        chk("B_starts", ms_cnt - ms0, 4);
        chk("B_xfer_done_count", xd_cnt - xd0, 1);
        for (int i = 0; i < 4; i++) chk("B_tx_order", sent_at(i), b4[i]);
        for (int i = 0; i < 4; i++) begin chk("B_rx_order", rd_data, r4[i]); pop_rx(); end

        // go with an empty TX FIFO
        pulse_go();
        chk("C_busy", busy, 1'b0);
        chk("C_cs", cs, 1'b1);
        tick(); tick();

        // mode sweep, cfg toggling during the transfer
        sl_fixed = 1'b0;
        for (int m = 0; m < 4; m++) begin
            cpol_cfg = m[1]; cpha_cfg = m[0];
            push(8'($urandom));
            pulse_go();
            cfg_toggle = 1'b1;
            wait_xd(60);
            cfg_toggle = 1'b0;
            chk("D_cpol", cpol, m[1]);
            chk("D_cpha", cpha, m[0]);
        end
        drain_rx();

        // fill TX past full, never read RX, then overflow RX
        for (int i = 0; i < D + 1; i++) push(8'(i + 8'h30));
        chk("E_tx_full", tx_full, 1'b1);
        ms0 = ms_cnt;
        pulse_go();
        wait_xd(300);
        chk("E_starts", ms_cnt - ms0, D);
        push(8'hC3);
        pulse_go();
        wait_xd(60);
        chk("E_starts_2", ms_cnt - ms0, D + 1);
`ifdef SPI_TXN_OVF_EN
        chk("E_rx_ovf", rx_ovf, 1'b1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("E_ovf_clr", rx_ovf, 1'b0);
`endif
        n = 0;
        for (int i = 0; i < 2 * D && rx_empty === 1'b0; i++) begin pop_rx(); n++; end
        chk("E_rx_count", n, D);

        // reset while waiting on the second byte
        sl_fixed = 1'b1; sl_q.delete();
        for (int i = 0; i < 3; i++) push(8'(8'hA0 + i));
        ms0 = ms_cnt; xd0 = xd_cnt;
        pulse_go();
        for (int i = 0; i < 60 && (ms_cnt - ms0) < 2; i++) tick();
        chk("G_reached_second", ms_cnt - ms0, 2);
        #2 reset = 1'b1;
        #1;
        chk("G_cs_async", cs, 1'b1);
        chk("G_busy", busy, 1'b0);
        chk("G_rx_empty", rx_empty, 1'b1);
        chk("G_tx_full", tx_full, 1'b0);
        model_reset();
        sl_cnt = 0; m_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("G_no_xfer_done", xd_cnt - xd0, 0);
        sl_q.push_back(8'h5A);
        push(8'h3C);
        pulse_go();
        wait_xd(60);
        chk("G_recovered", rd_data, 8'h5A);
        pop_rx();

        // random traffic: slow RX reads first (overflow likely), then fast
        sl_fixed = 1'b0; rnd_stall = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            wr_en = ($urandom_range(0, 2) == 0); wr_data = 8'($urandom);
            go = ($urandom_range(0, 9) == 0);
            rd_en = (i < 1500) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
            cpol_cfg = 1'($urandom); cpha_cfg = 1'($urandom);
`ifdef SPI_TXN_OVF_EN
            ovf_clr = ($urandom_range(0, 15) == 0);
`endif
            tick();
        end
        wr_en = 1'b0; go = 1'b0; rd_en = 1'b0;
`ifdef SPI_TXN_OVF_EN
        ovf_clr = 1'b0;
`endif
        for (int i = 0; i < 200 && busy === 1'b1; i++) tick();
        chk("R_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
